// File: rtl/ysyx_22051145_lsu_stage.sv
// Memory-access stage: one data-memory transaction per instruction over a
// valid/ready request and valid-only response, then aligned/extended writeback.
module ysyx_22051145_lsu_stage #(
  parameter int TIMEOUT = 255,
  parameter int RIDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_pc,
  input  logic [63:0]       in_exe_res,
  input  logic [63:0]       in_rs2,
  input  logic [RIDX_W-1:0] in_rd_idx,
  input  logic              in_rd_wen,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [63:0]       mem_req_addr,
  output logic [63:0]       mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_pc,
  output logic [RIDX_W-1:0] out_rd_idx,
  output logic              out_rd_wen,
  output logic [63:0]       out_wdata,
  output logic              out_misalign,
  output logic              out_bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [63:0]        r_pc;
  logic [RIDX_W-1:0]  r_rd_idx;
  logic               r_rd_wen, r_unsigned;
  logic [1:0]         r_size;
  logic [2:0]         r_off;

  logic               accept, is_mem, misalign;
  logic [7:0]         size_mask;
  logic [63:0]        st_data, ld_shift, ld_data;

  assign in_ready      = (state == IDLE) && (!out_valid || out_ready);
  assign accept        = in_valid && in_ready;
  assign is_mem        = in_is_load || in_is_store;
  assign mem_req_valid = (state == REQ);

  always_comb begin
    size_mask = 8'h00;
    misalign  = 1'b0;
    st_data   = 64'h0;
    case (in_size)
      2'd0: begin size_mask = 8'h01; st_data = {56'h0, in_rs2[7:0]}; end
      2'd1: begin size_mask = 8'h03; st_data = {48'h0, in_rs2[15:0]};
                  misalign = in_exe_res[0]; end
      2'd2: begin size_mask = 8'h0f; st_data = {32'h0, in_rs2[31:0]};
                  misalign = |in_exe_res[1:0]; end
      default: begin size_mask = 8'hff; st_data = in_rs2;
                  misalign = |in_exe_res[2:0]; end
    endcase
  end

  // Bring the addressed lane down to bit 0, then truncate and extend.
  assign ld_shift = mem_resp_rdata >> {r_off, 3'b000};
  always_comb begin
    ld_data = ld_shift;
    case (r_size)
      2'd0: ld_data = r_unsigned ? {56'h0, ld_shift[7:0]}  : {{56{ld_shift[7]}},  ld_shift[7:0]};
      2'd1: ld_data = r_unsigned ? {48'h0, ld_shift[15:0]} : {{48{ld_shift[15]}}, ld_shift[15:0]};
      2'd2: ld_data = r_unsigned ? {32'h0, ld_shift[31:0]} : {{32{ld_shift[31]}}, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      r_pc          <= '0;
      r_rd_idx      <= '0;
      r_rd_wen      <= 1'b0;
      r_unsigned    <= 1'b0;
      r_size        <= '0;
      r_off         <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rd_idx    <= '0;
      out_rd_wen    <= 1'b0;
      out_wdata     <= '0;
      out_misalign  <= 1'b0;
      out_bus_err   <= 1'b0;
    end else begin
      // Drain first; a result loaded below in the same cycle overrides this.
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          r_pc       <= in_pc;
          r_rd_idx   <= in_rd_idx;
          r_rd_wen   <= in_rd_wen;
          r_unsigned <= in_unsigned;
          r_size     <= in_size;
          r_off      <= in_exe_res[2:0];
          if (!is_mem || misalign) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_rd_idx   <= in_rd_idx;
            out_rd_wen   <= is_mem ? 1'b0 : in_rd_wen;
            out_wdata    <= is_mem ? 64'h0 : in_exe_res;
            out_misalign <= is_mem;
            out_bus_err  <= 1'b0;
          end else begin
            state         <= REQ;
            mem_req_wen   <= in_is_store;
            mem_req_addr  <= {in_exe_res[63:3], 3'b000};
            mem_req_wdata <= st_data << {in_exe_res[2:0], 3'b000};
            mem_req_wmask <= in_is_store ? (size_mask << in_exe_res[2:0]) : 8'h00;
          end
        end
        REQ: if (mem_req_ready) begin
          state <= RESP;
          cnt   <= '0;
        end
        RESP: begin
          if (mem_resp_valid) begin
            state        <= IDLE;
            out_valid    <= 1'b1;
            out_pc       <= r_pc;
            out_rd_idx   <= r_rd_idx;
            out_rd_wen   <= mem_req_wen ? 1'b0 : r_rd_wen;
            out_wdata    <= mem_req_wen ? 64'h0 : ld_data;
            out_misalign <= 1'b0;
            out_bus_err  <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state        <= IDLE;
            out_valid    <= 1'b1;
            out_pc       <= r_pc;
            out_rd_idx   <= r_rd_idx;
            out_rd_wen   <= 1'b0;
            out_wdata    <= 64'h0;
            out_misalign <= 1'b0;
            out_bus_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22051145_lsu_stage.sv
// Directed bench for the LSU stage; inputs driven and outputs sampled on negedge.
module tb_ysyx_22051145_lsu_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid, in_ready, in_rd_wen, in_is_load, in_is_store, in_unsigned;
  logic [63:0] in_pc, in_exe_res, in_rs2;
  logic [4:0]  in_rd_idx, out_rd_idx;
  logic [1:0]  in_size;
  logic mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [7:0]  mem_req_wmask;
  logic out_valid, out_ready, out_rd_wen, out_misalign, out_bus_err;
  logic [63:0] out_pc, out_wdata;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  ysyx_22051145_lsu_stage #(.TIMEOUT(255), .RIDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_exe_res(in_exe_res), .in_rs2(in_rs2),
    .in_rd_idx(in_rd_idx), .in_rd_wen(in_rd_wen), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_size(in_size), .in_unsigned(in_unsigned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd_idx(out_rd_idx), .out_rd_wen(out_rd_wen), .out_wdata(out_wdata),
    .out_misalign(out_misalign), .out_bus_err(out_bus_err));

  task automatic drive_in(input logic [63:0] res, rs2, input logic ld, st,
                          input logic [1:0] sz, input logic uns);
    in_valid = 1'b1; in_pc = 64'h100; in_exe_res = res; in_rs2 = rs2;
    in_rd_idx = 5'd7; in_rd_wen = 1'b1; in_is_load = ld; in_is_store = st;
    in_size = sz; in_unsigned = uns;
  endtask

  // Runs one aligned access with an immediate ack; returns what was observed.
  task automatic run_mem(input logic st, input logic [63:0] addr, rs2, rdata,
                         input logic [1:0] sz, input logic uns,
                         output logic [63:0] r_addr, r_wdata, o_wdata,
                         output logic [7:0] r_wmask,
                         output logic r_vld, r_wen, o_vld, o_rd_wen);
    @(negedge clk);
    drive_in(addr, rs2, !st, st, sz, uns); mem_req_ready = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    for (int k = 0; k < 10 && !mem_req_valid; k++) @(negedge clk);
    r_vld = mem_req_valid; r_addr = mem_req_addr; r_wdata = mem_req_wdata;
    r_wmask = mem_req_wmask; r_wen = mem_req_wen;
    @(negedge clk); mem_resp_valid = 1'b1; mem_resp_rdata = rdata; mem_req_ready = 1'b0;
    @(negedge clk); mem_resp_valid = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    o_vld = out_valid; o_wdata = out_wdata; o_rd_wen = out_rd_wen;
  endtask

  task automatic test_reset;
    n_cmp++; if ({mem_req_valid, out_valid, out_wdata, mem_req_addr, out_misalign, out_bus_err} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: req_valid=%b out_valid=%b out_wdata=%h", mem_req_valid, out_valid, out_wdata); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back;
    logic seen_req = 1'b0;
    @(negedge clk); out_ready = 1'b1; drive_in(64'h11, 64'h0, 1'b0, 1'b0, 2'd3, 1'b0);
    @(negedge clk); seen_req |= mem_req_valid; in_exe_res = 64'h22;
    n_cmp++; if (out_valid !== 1'b1 || out_wdata !== 64'h11) begin
      n_bad++; $display("FAIL b2b_first: valid=%b wdata=%h want 1/11", out_valid, out_wdata); end
    @(negedge clk); seen_req |= mem_req_valid; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_wdata !== 64'h22) begin
      n_bad++; $display("FAIL b2b_second: valid=%b wdata=%h want 1/22", out_valid, out_wdata); end
    @(negedge clk); seen_req |= mem_req_valid;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: valid=%b want 0", out_valid); end
    n_cmp++; if (seen_req !== 1'b0) begin n_bad++; $display("FAIL b2b_no_req: mem_req_valid seen=%b want 0", seen_req); end
  endtask

  task automatic test_load_byte;
    logic [63:0] ra, rw, ow; logic [7:0] rm; logic rv, re, ov, orw;
    run_mem(1'b0, 64'h8003, 64'h0, 64'h0000_0000_8000_0000, 2'd0, 1'b0, ra, rw, ow, rm, rv, re, ov, orw);
    n_cmp++; if (rv !== 1'b1 || ra !== 64'h8000 || re !== 1'b0 || rm !== 8'h00) begin
      n_bad++; $display("FAIL lb_req: valid=%b addr=%h wen=%b wmask=%h want 1/8000/0/00", rv, ra, re, rm); end
    n_cmp++; if (ov !== 1'b1 || ow !== 64'hFFFF_FFFF_FFFF_FF80 || orw !== 1'b1) begin
      n_bad++; $display("FAIL lb_data: valid=%b wdata=%h rd_wen=%b want 1/ffffffffffffff80/1", ov, ow, orw); end
    run_mem(1'b0, 64'h8003, 64'h0, 64'h0000_0000_8000_0000, 2'd0, 1'b1, ra, rw, ow, rm, rv, re, ov, orw);
    n_cmp++; if (ov !== 1'b1 || ow !== 64'h80) begin
      n_bad++; $display("FAIL lbu_data: valid=%b wdata=%h want 1/80", ov, ow); end
    run_mem(1'b0, 64'h8006, 64'h0, 64'hBEEF_1234_5678_9ABC, 2'd1, 1'b0, ra, rw, ow, rm, rv, re, ov, orw);
    n_cmp++; if (ow !== 64'hFFFF_FFFF_FFFF_BEEF) begin
      n_bad++; $display("FAIL lh_data: wdata=%h want ffffffffffffbeef", ow); end
  endtask

  task automatic test_store_word;
    logic [63:0] ra, rw, ow; logic [7:0] rm; logic rv, re, ov, orw;
    run_mem(1'b1, 64'h1004, 64'hDEADBEEF, 64'h0, 2'd2, 1'b0, ra, rw, ow, rm, rv, re, ov, orw);
    n_cmp++; if (re !== 1'b1 || rm !== 8'hF0 || rw !== 64'hDEADBEEF_0000_0000 || ra !== 64'h1000) begin
      n_bad++; $display("FAIL sw_req: wen=%b wmask=%h wdata=%h addr=%h want 1/f0/deadbeef00000000/1000", re, rm, rw, ra); end
    n_cmp++; if (ov !== 1'b1 || orw !== 1'b0 || ow !== 64'h0) begin
      n_bad++; $display("FAIL sw_out: valid=%b rd_wen=%b wdata=%h want 1/0/0", ov, orw, ow); end
    run_mem(1'b1, 64'h1005, 64'hAB, 64'h0, 2'd0, 1'b0, ra, rw, ow, rm, rv, re, ov, orw);
    n_cmp++; if (rm !== 8'h20 || rw !== 64'h0000_AB00_0000_0000) begin
      n_bad++; $display("FAIL sb_req: wmask=%h wdata=%h want 20/0000ab0000000000", rm, rw); end
  endtask

  task automatic test_misalign;
    @(negedge clk); out_ready = 1'b1; drive_in(64'h1002, 64'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_rd_wen !== 1'b0 || out_wdata !== 64'h0 || mem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL misalign: valid=%b mis=%b rd_wen=%b wdata=%h req=%b want 1/1/0/0/0",
                        out_valid, out_misalign, out_rd_wen, out_wdata, mem_req_valid); end
    @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL misalign_after: req=%b valid=%b want 0/0", mem_req_valid, out_valid); end
  endtask

  task automatic test_stall;
    logic ok = 1'b1;
    @(negedge clk); out_ready = 1'b1; mem_req_ready = 1'b0;
    drive_in(64'h2000, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h2000 || mem_req_wmask !== 8'h00 || in_ready !== 1'b0) ok = 1'b0;
      if (k < 3) @(negedge clk);
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL req_hold: addr=%h req=%b in_ready=%b", mem_req_addr, mem_req_valid, in_ready); end
    mem_req_ready = 1'b1;
    @(negedge clk); mem_req_ready = 1'b0; out_ready = 1'b0;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL req_drop: req=%b want 0", mem_req_valid); end
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); mem_resp_valid = 1'b0; ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (out_valid !== 1'b1 || out_wdata !== 64'h0123_4567_89AB_CDEF || out_rd_idx !== 5'd7 || in_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL out_hold: valid=%b wdata=%h in_ready=%b", out_valid, out_wdata, in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL out_release: valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_timeout;
    int n = 0;
    @(negedge clk); out_ready = 1'b1; mem_req_ready = 1'b1;
    drive_in(64'h3000, 64'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); mem_req_ready = 1'b0;
    while (!out_valid && n < 400) begin n++; @(negedge clk); end
    n_cmp++; if (n !== 255) begin n_bad++; $display("FAIL timeout_cycles: waited %0d want 255", n); end
    n_cmp++; if (out_valid !== 1'b1 || out_bus_err !== 1'b1 || out_rd_wen !== 1'b0 || out_misalign !== 1'b0) begin
      n_bad++; $display("FAIL timeout_flags: valid=%b bus_err=%b rd_wen=%b mis=%b want 1/1/0/0",
                        out_valid, out_bus_err, out_rd_wen, out_misalign); end
  endtask

  task automatic test_reset_in_resp;
    @(negedge clk); out_ready = 1'b1; mem_req_ready = 1'b1;
    drive_in(64'h4000, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); mem_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; #1;
    n_cmp++; if ({mem_req_valid, out_valid, out_wdata, out_bus_err, mem_req_addr, mem_req_wen} !== '0) begin
      n_bad++; $display("FAIL reset_mid: req=%b valid=%b addr=%h want all 0", mem_req_valid, out_valid, mem_req_addr); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: in_ready=%b req=%b want 1/0", in_ready, mem_req_valid); end
    drive_in(64'h55, 64'h0, 1'b0, 1'b0, 2'd3, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_wdata !== 64'h55 || out_bus_err !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_alu: valid=%b wdata=%h err=%b want 1/55/0", out_valid, out_wdata, out_bus_err); end
  endtask

  initial begin
    in_valid = 1'b0; in_pc = '0; in_exe_res = '0; in_rs2 = '0; in_rd_idx = '0;
    in_rd_wen = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_size = '0;
    in_unsigned = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_rdata = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_back_to_back;
    test_load_byte;
    test_store_word;
    test_misalign;
    test_stall;
    test_timeout;
    test_reset_in_resp;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22051145_lsu_stage.md
Name: ysyx_22051145_lsu_stage

Overview:
Memory-access stage directly downstream of the execute stage. It consumes the execute result, which is either an ALU value or an effective address, plus rs2 and the decoded load/store controls. It performs at most one data-memory transaction through a valid/ready request interface and a valid-only response interface. It then hands the aligned, sign- or zero-extended writeback value to the writeback stage.

Parameters:
TIMEOUT, 255, cycles waited in RESP before the transaction is abandoned with a bus error
RIDX_W, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute-stage result valid
in_ready  out  1  stage can accept
in_pc  in  64  instruction PC
in_exe_res  in  64  execute result (effective address when is_load/is_store)
in_rs2  in  64  store data
in_rd_idx  in  RIDX_W  destination register
in_rd_wen  in  1  destination write enable
in_is_load  in  1  load instruction
in_is_store  in  1  store instruction
in_size  in  2  0=byte 1=half 2=word 3=double
in_unsigned  in  1  zero-extend load
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_wen  out  1  1=store
mem_req_addr  out  64  8-byte-aligned address
mem_req_wdata  out  64  lane-shifted store data
mem_req_wmask  out  8  byte-lane mask
mem_resp_valid  in  1  response/ack valid
mem_resp_rdata  in  64  read doubleword
out_valid  out  1  writeback payload valid
out_ready  in  1  writeback accepts
out_pc  out  64  PC
out_rd_idx  out  RIDX_W  destination register
out_rd_wen  out  1  destination write enable
out_wdata  out  64  writeback data
out_misalign  out  1  access misaligned, suppressed
out_bus_err  out  1  response timeout

Behaviour:
- Reset: every output and register is cleared to 0; state = IDLE. The reset is asynchronous, so it takes effect mid-transaction as well. Any in-flight request is abandoned; memory is assumed reset with the core.
- States: IDLE, REQ, RESP. Output holding register is independent (out_valid).
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept (in_valid && in_ready):
  - Non-memory op: next cycle out_valid=1, out_wdata=in_exe_res, other fields copied. Sustains 1 instr/cycle.
  - Memory op with offset = in_exe_res[2:0]:
    - Misaligned when offset is not a multiple of 2^size.
    - If misaligned: no request. out_valid=1 next cycle with out_misalign=1, out_rd_wen=0, out_wdata=0.
    - If aligned: latch the request and go to REQ.
- REQ:
  - Drives mem_req_valid=1 with addr={res[63:3],3'b000}.
  - wmask = ((1<<2^size)-1) << offset for stores; 0 for loads.
  - wdata = (in_rs2 masked to size) << (offset*8).
  - Payload is held stable until mem_req_ready. On handshake go to RESP and clear the counter.
  - mem_resp_valid is ignored while in REQ.
- RESP:
  - Counter increments each cycle.
  - On mem_resp_valid: out_valid=1 next cycle and state goes to IDLE.
    - Load: out_wdata = (rdata >> offset*8), truncated to size, then extended per in_unsigned.
    - Store: out_rd_wen=0 and out_wdata=0.
  - If the counter reaches TIMEOUT without a response: out_valid=1, out_bus_err=1, out_rd_wen=0, state goes to IDLE.
- Output register:
  - Holds all out_* stable while out_valid && !out_ready.
  - Clears out_valid on out_ready unless a new result is loaded in the same cycle.
- in_ready gating guarantees the output register is empty whenever a memory transaction completes.
- Latency: non-memory and misaligned ops take 1 cycle. Memory ops take at least 3 cycles: accept, request, response.
- The error flags (out_misalign, out_bus_err) are per-payload and cleared with the next loaded result.

Test Plan:
- Back-to-back ALU results 0x11, 0x22 with out_ready=1: out_valid on consecutive cycles, out_wdata 0x11 then 0x22, mem_req_valid never asserted.
- LB at addr 0x8003, rdata 0x0000_0000_8000_0000: mem_req_addr 0x8000, out_wdata 0xFFFF_FFFF_FFFF_FF80. Same access as LBU gives 0x80.
- SW at addr 0x1004, rs2 0xDEADBEEF: mem_req_wen=1, wmask 0xF0, wdata 0xDEADBEEF_00000000, out_rd_wen=0.
- LW at addr 0x1002: no mem_req_valid, out_misalign=1, out_rd_wen=0.
- Hold mem_req_ready=0 for 4 cycles, then out_ready=0 for 3 cycles: request payload stable throughout, in_ready=0, out_* stable until ready.
- No response for 255 cycles gives out_bus_err=1. Assert rst_n=0 during RESP: all outputs 0, state IDLE, in_ready=1 after release.
